sort_frame_ctrl: RTL

SORT_FRAME_CTRL -- requirements
Module: sort_frame_ctrl

---
 rtl/sort_frame_pkg.sv | 25 ++
 rtl/sort_frame_ser.sv | 96 +++++++++
 rtl/sort_frame_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sort_frame_pkg.sv
// Shared types and constants for the sort frame controller.
//   state_e : controller FSM states
//   mode_e  : requested output order (ascending / descending)
//   CMD_ASC, CMD_DESC : command bytes that open a frame
//   ERR_BYTE : byte returned for an unknown command
package sort_frame_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StSort,
      StSend,
      StErr
   } state_e;

   typedef enum logic {
      ModeAsc,
      ModeDesc
   } mode_e;

   localparam logic [7:0] CMD_ASC  = 8'hA5;
   localparam logic [7:0] CMD_DESC = 8'h5A;
   localparam logic [7:0] ERR_BYTE = 8'hEE;

endpackage

// File: rtl/sort_frame_ser.sv
// Output buffer and byte serialiser for the sort frame controller.
// Captures a sorted frame on load_i and emits it one byte at a time,
// each element LSB-first, elements in ascending or descending index order.
//   clk, rst_n  : clock, synchronous active-low reset
//   load_i      : capture data_i / desc_i and start sending
//   data_i      : N*WIDTH sorted elements
//   desc_i      : 1 = send element N-1 first
//   tx_*        : valid/ready byte stream; data is 0 while idle
//   last_o      : final byte of the frame is transferring this cycle
module sort_frame_ser #(
   parameter int unsigned N     = 8,
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [N*WIDTH-1:0] data_i,
   input  logic               desc_i,
   output logic [7:0]         tx_data_o,
   output logic               tx_valid_o,
   input  logic               tx_ready_i,
   output logic               last_o
);

   localparam int unsigned B    = WIDTH / 8;
   localparam int unsigned NB   = N * B;
   localparam int unsigned CntW = $clog2(NB + 1);
   localparam int unsigned ElW  = $clog2(N);
   localparam int unsigned BtW  = (B > 1) ? $clog2(B) : 1;

   logic [N*WIDTH-1:0] buf_q, buf_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [ElW-1:0]     el_q, el_d;
   logic [BtW-1:0]     bt_q, bt_d;
   logic               active_q, active_d;
   logic               desc_q, desc_d;
   logic [ElW-1:0]     el_sel;
   logic               accept;

   always_comb begin
      buf_d      = buf_q;
      cnt_d      = cnt_q;
      el_d       = el_q;
      bt_d       = bt_q;
      active_d   = active_q;
      desc_d     = desc_q;
      el_sel     = desc_q ? (ElW'(N - 1) - el_q) : el_q;
      tx_valid_o = active_q;
      tx_data_o  = active_q ? buf_q[(int'(el_sel) * B + int'(bt_q)) * 8 +: 8] : 8'h00;
      accept     = active_q && tx_ready_i;
      last_o     = accept && (cnt_q == CntW'(NB - 1));

      if (load_i) begin
         buf_d    = data_i;
         desc_d   = desc_i;
         cnt_d    = '0;
         el_d     = '0;
         bt_d     = '0;
         active_d = 1'b1;
      end else if (accept) begin
         if (last_o) begin
            active_d = 1'b0;
            cnt_d    = '0;
            el_d     = '0;
            bt_d     = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (bt_q == BtW'(B - 1)) begin
               bt_d = '0;
               el_d = el_q + 1'b1;
            end else begin
               bt_d = bt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         buf_q    <= '0;
         cnt_q    <= '0;
         el_q     <= '0;
         bt_q     <= '0;
         active_q <= 1'b0;
         desc_q   <= 1'b0;
      end else begin
         buf_q    <= buf_d;
         cnt_q    <= cnt_d;
         el_q     <= el_d;
         bt_q     <= bt_d;
         active_q <= active_d;
         desc_q   <= desc_d;
      end
   end

endmodule

// File: rtl/sort_frame_ctrl.sv
// UART-framed sort controller. Receives a command byte (A5 ascending,
// 5A descending) and N elements of WIDTH bits LSB-first, hands the frame
// to an external sorter, then streams the sorted result back out.
//   clk, rst_n        : clock, synchronous active-low reset
//   rx_*              : inbound byte stream (valid/ready)
//   tx_*              : outbound byte stream (valid/ready)
//   sort_start_o      : one-cycle sort request
//   sort_data_o/_i    : frame to / sorted frame from the sorter
//   sort_done_i       : sorter result valid
//   busy_o            : controller not idle
//   timeout_cnt_o     : saturating count of frames aborted by timeout
module sort_frame_ctrl
   import sort_frame_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         rx_data_i,
   input  logic               rx_valid_i,
   output logic               rx_ready_o,
   output logic [7:0]         tx_data_o,
   output logic               tx_valid_o,
   input  logic               tx_ready_i,
   output logic               sort_start_o,
   output logic [N*WIDTH-1:0] sort_data_o,
   input  logic [N*WIDTH-1:0] sort_data_i,
   input  logic               sort_done_i,
   output logic               busy_o,
   output logic [7:0]         timeout_cnt_o
);

   localparam int unsigned B     = WIDTH / 8;
   localparam int unsigned NB    = N * B;
   localparam int unsigned CntW  = $clog2(NB + 1);
   localparam int unsigned IdleW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_e             state_q, state_d;
   mode_e              mode_q, mode_d;
   logic [CntW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [IdleW-1:0]   idle_cnt_q, idle_cnt_d;
   logic [N*WIDTH-1:0] elem_q, elem_d;
   logic               start_q, start_d;
   logic [7:0]         tmo_q, tmo_d;
   logic               rx_fire;
   logic               ser_load;
   logic               ser_last;
   logic               ser_valid;
   logic [7:0]         ser_data;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      byte_cnt_d = byte_cnt_q;
      idle_cnt_d = idle_cnt_q;
      elem_d     = elem_q;
      start_d    = 1'b0;
      tmo_d      = tmo_q;
      ser_load   = 1'b0;
      // Held low through reset regardless of the stale state register.
      rx_ready_o = rst_n && ((state_q == StIdle) || (state_q == StCollect));
      rx_fire    = rx_valid_i && rx_ready_o;

      unique case (state_q)
         StIdle: begin
            if (rx_fire) begin
               byte_cnt_d = '0;
               idle_cnt_d = '0;
               if (rx_data_i == CMD_ASC) begin
                  mode_d  = ModeAsc;
                  state_d = StCollect;
               end else if (rx_data_i == CMD_DESC) begin
                  mode_d  = ModeDesc;
                  state_d = StCollect;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StCollect: begin
            if (rx_fire) begin
               // Byte k of the frame lands at bits k*8: LSB-first per element.
               elem_d[int'(byte_cnt_q) * 8 +: 8] = rx_data_i;
               idle_cnt_d = '0;
               if (byte_cnt_q == CntW'(NB - 1)) begin
                  byte_cnt_d = '0;
                  start_d    = 1'b1;
                  state_d    = StSort;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (TIMEOUT != 0) begin
               if (idle_cnt_q == IdleW'(TIMEOUT - 1)) begin
                  state_d    = StIdle;
                  idle_cnt_d = '0;
                  byte_cnt_d = '0;
                  if (tmo_q != 8'hFF) tmo_d = tmo_q + 1'b1;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         StSort: begin
            // A done level coinciding with our own start belongs to a stale job.
            if (sort_done_i && !start_q) begin
               ser_load = 1'b1;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (ser_last) state_d = StIdle;
         end
         StErr: begin
            if (tx_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      tx_valid_o    = (state_q == StErr) || ser_valid;
      tx_data_o     = (state_q == StErr) ? ERR_BYTE : ser_data;
      busy_o        = (state_q != StIdle);
      sort_start_o  = start_q;
      sort_data_o   = elem_q;
      timeout_cnt_o = tmo_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         mode_q     <= ModeAsc;
         byte_cnt_q <= '0;
         idle_cnt_q <= '0;
         elem_q     <= '0;
         start_q    <= 1'b0;
         tmo_q      <= 8'h00;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         byte_cnt_q <= byte_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         elem_q     <= elem_d;
         start_q    <= start_d;
         tmo_q      <= tmo_d;
      end
   end

   sort_frame_ser #(
      .N     (N),
      .WIDTH (WIDTH)
   ) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ser_load),
      .data_i     (sort_data_i),
      .desc_i     (mode_q == ModeDesc),
      .tx_data_o  (ser_data),
      .tx_valid_o (ser_valid),
      .tx_ready_i (tx_ready_i),
      .last_o     (ser_last)
   );

endmodule
